// File: rtl/sar_adc.sv
// Successive-approximation ADC: behavioural real-valued sample/hold and comparator
// around a registered bit-serial search, with a valid/ready result handshake.
module sar_adc #(
    parameter int  bits = 8,
    parameter real vref = 1.0
) (
    input  logic            clk,
    input  logic            rst,
    input  real             vin,
    input  logic            start,
    output logic            busy,
    output logic [0:bits-1] code,
    output logic            valid,
    input  logic            ready
);

    localparam int  IW  = (bits > 1) ? $clog2(bits) : 1;
    localparam real LSB = vref / (2.0 ** bits);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    state_t          state, state_nxt;
    real             held;
    logic [0:bits-1] trial, trial_nxt;
    logic [IW-1:0]   idx, idx_p1;
    logic            last_step;

    assign last_step = (idx == IW'(bits - 1));
    assign idx_p1    = idx + 1'b1;
    assign busy      = (state == SAMPLE) || (state == CONVERT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = CONVERT;
            CONVERT: if (last_step) state_nxt = DONE;
            DONE:    if (ready) state_nxt = start ? SAMPLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One comparator decision per cycle: drop the bit under test if the trial
    // level overshoots the held input, then tentatively raise the next bit.
    always_comb begin
        trial_nxt = trial;
        if (held < real'(trial) * LSB) trial_nxt[idx] = 1'b0;
        if (!last_step)                trial_nxt[idx_p1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held  <= 0.0;
            trial <= '0;
            idx   <= '0;
            code  <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                SAMPLE: begin
                    held     <= (vin < 0.0) ? 0.0 : ((vin > vref) ? vref : vin);
                    trial    <= '0;
                    trial[0] <= 1'b1;
                    idx      <= '0;
                end
                CONVERT: begin
                    trial <= trial_nxt;
                    idx   <= idx_p1;
                    // code only ever sees the finished result, never a trial value
                    if (last_step) begin
                        code  <= trial_nxt;
                        valid <= 1'b1;
                    end
                end
                DONE: if (ready) valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc.sv
// Directed bench for sar_adc: latency, known codes, clamping, hold under
// back-pressure, reset abort, back-to-back conversions and random inputs.
module tb_sar_adc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    real        vin = 0.0;
    logic       start = 1'b0;
    logic       busy;
    logic [0:7] code;
    logic       valid;
    logic       ready = 1'b1;

    int checks = 0;
    int errors = 0;

    sar_adc #(.bits(8), .vref(1.0)) dut (
        .clk(clk), .rst(rst), .vin(vin), .start(start),
        .busy(busy), .code(code), .valid(valid), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One conversion from IDLE. valid must show after the 10th edge counting the
    // edge that samples start. vin is disturbed and a stray start is pulsed mid-way.
    task automatic run(input string tag, input real v, input longint exp_code);
        int n;
        vin = v; start = 1'b1;
        tick(); n = 1;
        start = 1'b0;
        while (!valid && n < 30) begin
            tick(); n++;
            if (n == 2) begin
                check({tag, "_busy"}, busy, 1);
                vin = 2.0 - v;
            end
            if (n == 4) start = 1'b1;
            if (n == 5) start = 1'b0;
        end
        check({tag, "_lat"}, n, 10);
        check({tag, "_code"}, code, exp_code);
        if (ready) begin
            tick();
            check({tag, "_drop"}, valid, 0);
            check({tag, "_keep"}, code, exp_code);
        end
    endtask

    initial begin
        int nv, first, second, n;
        real v, c;
        longint exp_code;

        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_code", code, 0);
        rst = 1'b0;

        run("half", 0.5, 8'h80);
        run("p3", 0.3, 8'h4C);
        run("fs", 1.0, 8'hFF);
        run("over", 1.7, 8'hFF);
        run("neg", -0.3, 8'h00);
        run("p75", 0.75, 8'hC0);
        run("p1", 0.1, 8'h19);
        run("tiny", 0.0039, 8'h00);

        // back-pressure: result must hold while ready is low
        ready = 1'b0;
        run("bp", 0.3, 8'h4C);
        for (int i = 0; i < 5; i++) begin
            vin = (i % 2) ? 0.9 : -0.4;
            start = (i == 2);
            tick();
            check("bp_valid", valid, 1);
            check("bp_code", code, 8'h4C);
        end
        start = 1'b0; ready = 1'b1;
        tick();
        check("bp_drop", valid, 0);
        check("bp_idle", busy, 0);
        tick();
        check("bp_no_restart", busy, 0);

        // reset during CONVERT step 3 aborts with no result
        vin = 0.5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_code", code, 0);
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid) nv++;
        end
        check("abort_no_valid", nv, 0);
        run("after_rst", 0.25, 8'h40);

        // start held high: one result every 10 edges
        vin = 0.5; start = 1'b1;
        nv = 0; first = 0; second = 0;
        for (int i = 1; i <= 35; i++) begin
            tick();
            if (valid) begin
                nv++;
                if (first == 0) first = i;
                else if (second == 0) second = i;
                check("b2b_code", code, 8'h80);
            end
        end
        start = 1'b0;
        check("b2b_count", nv, 3);
        check("b2b_first", first, 10);
        check("b2b_period", second - first, 10);
        n = 0;
        while ((busy || valid) && n < 30) begin
            tick(); n++;
        end
        check("b2b_drain", busy || valid, 0);

        // random inputs across [-2, 2]
        for (int k = 0; k < 12; k++) begin
            v = (real'($urandom_range(4000, 0)) - 2000.0) / 1000.0;
            c = (v < 0.0) ? 0.0 : ((v > 1.0) ? 1.0 : v);
            exp_code = (c >= 1.0) ? 255 : longint'($floor(c * 256.0));
            run("rand", v, exp_code);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
